// File: rtl/servo_ramp_sched.sv
// servo_ramp_sched: once per PWM frame, walks all channels, slews cur toward tgt and
// writes each changed width as two register bytes. Step limiting: SERVO_RAMP_SCHED_RAMP_EN.
//
// state  | meaning
// IDLE   | waiting for a frame tick or a pending tick
// CALC   | update cur[ch] toward tgt[ch], decide whether a write is needed
// WR_LO  | write cur[7:0] to {ch,0}, held until Wr_Ready
// WR_HI  | write cur[14:8] to {ch,1}, held until Wr_Ready
// NEXT   | advance channel or finish the sweep
module servo_ramp_sched #(
    parameter int          NCH      = 8,
    parameter logic [14:0] PW_MIN   = 15'd1000,
    parameter logic [14:0] PW_MAX   = 15'd2000,
    parameter logic [14:0] RESET_PW = 15'd1500
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        Frame_Tick,
    input  logic        Tgt_WEn,
    input  logic [2:0]  Tgt_Ch,
    input  logic [14:0] Tgt_Val,
    input  logic [7:0]  Step,
    output logic [7:0]  Wr_Addr,
    output logic [7:0]  Wr_Data,
    output logic        Wr_En,
    input  logic        Wr_Ready,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_WR_LO, S_WR_HI, S_NEXT} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_ch;
    logic        r_pend;
    logic        r_init;
    logic [14:0] r_tgt [NCH];
    logic [14:0] r_cur [NCH];

    logic [14:0] w_cur_sel, w_tgt_sel, w_cur_nxt, w_clamp;
    logic        w_last, w_tgt_ok;

    assign w_cur_sel = r_cur[r_ch];
    assign w_tgt_sel = r_tgt[r_ch];
    assign w_last    = (r_ch == 3'(NCH - 1));
    assign w_tgt_ok  = ({1'b0, Tgt_Ch} < 4'(NCH));
    assign w_clamp   = (Tgt_Val < PW_MIN) ? PW_MIN :
                       (Tgt_Val > PW_MAX) ? PW_MAX : Tgt_Val;

`ifdef SERVO_RAMP_SCHED_RAMP_EN
    logic [14:0] w_diff, w_stp;
    logic        w_up;

    // Limiting the move to min(|d|, Step) guarantees no overshoot past tgt.
    always_comb begin
        w_up      = (w_tgt_sel >= w_cur_sel);
        w_diff    = w_up ? (w_tgt_sel - w_cur_sel) : (w_cur_sel - w_tgt_sel);
        w_stp     = (w_diff < {7'd0, Step}) ? w_diff : {7'd0, Step};
        w_cur_nxt = w_up ? (w_cur_sel + w_stp) : (w_cur_sel - w_stp);
    end
`else
    logic w_unused_step;
    assign w_unused_step = ^Step;
    assign w_cur_nxt     = w_tgt_sel;
`endif

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        Wr_En       = 1'b0;
        Wr_Addr     = 8'd0;
        Wr_Data     = 8'd0;
        Done        = 1'b0;
        Busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (Frame_Tick || r_pend) w_state_nxt = S_CALC;
            S_CALC: w_state_nxt = ((w_cur_nxt != w_cur_sel) || r_init) ? S_WR_LO : S_NEXT;
            S_WR_LO: begin
                Wr_En   = 1'b1;
                Wr_Addr = {4'd0, r_ch, 1'b0};
                Wr_Data = w_cur_sel[7:0];
                if (Wr_Ready) w_state_nxt = S_WR_HI;
            end
            S_WR_HI: begin
                Wr_En   = 1'b1;
                Wr_Addr = {4'd0, r_ch, 1'b1};
                Wr_Data = {1'b0, w_cur_sel[14:8]};
                if (Wr_Ready) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (w_last) begin
                    Done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_ch   <= 3'd0;
            r_pend <= 1'b0;
            r_init <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
                r_tgt[i] <= RESET_PW;
                r_cur[i] <= RESET_PW;
            end
        end else begin
            if (Tgt_WEn && w_tgt_ok) r_tgt[Tgt_Ch] <= w_clamp;
            // Pending only sets while busy and only clears from IDLE, so they never collide.
            if (Frame_Tick && (r_state != S_IDLE)) r_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_CALC) begin
                        r_ch   <= 3'd0;
                        r_pend <= 1'b0;
                    end
                end
                S_CALC: r_cur[r_ch] <= w_cur_nxt;
                S_NEXT: begin
                    if (w_last) r_init <= 1'b0;
                    else        r_ch   <= r_ch + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_ramp_sched.sv
// tb_servo_ramp_sched: randomized frames against a per-frame sweep model of the
// scheduler; write stream, Done, Busy duration and stall stability are compared.
module tb_servo_ramp_sched;

    localparam int NCH      = 8;
    localparam int PW_MIN   = 1000;
    localparam int PW_MAX   = 2000;
    localparam int RESET_PW = 1500;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic        Frame_Tick = 1'b0;
    logic        Tgt_WEn = 1'b0;
    logic [2:0]  Tgt_Ch = 3'd0;
    logic [14:0] Tgt_Val = 15'd0;
    logic [7:0]  Step = 8'd0;
    logic [7:0]  Wr_Addr, Wr_Data;
    logic        Wr_En;
    logic        Wr_Ready = 1'b1;
    logic        Busy, Done;

    servo_ramp_sched #(
        .NCH(NCH), .PW_MIN(15'(PW_MIN)), .PW_MAX(15'(PW_MAX)), .RESET_PW(15'(RESET_PW))
    ) u_dut (
        .Clk(Clk), .rst(rst), .Frame_Tick(Frame_Tick), .Tgt_WEn(Tgt_WEn),
        .Tgt_Ch(Tgt_Ch), .Tgt_Val(Tgt_Val), .Step(Step), .Wr_Addr(Wr_Addr),
        .Wr_Data(Wr_Data), .Wr_En(Wr_En), .Wr_Ready(Wr_Ready), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // behavioural reference
    int   m_tgt [NCH];
    int   m_cur [NCH];
    bit   m_init;
    int   exp_busy;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    function automatic int clamp_pw(int v);
        if (v < PW_MIN) return PW_MIN;
        if (v > PW_MAX) return PW_MAX;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = RESET_PW;
            m_cur[i] = RESET_PW;
        end
        m_init = 1'b1;
    endfunction

    function automatic void model_sweep(int stp);
        for (int c = 0; c < NCH; c++) begin
            int nv;
`ifdef SERVO_RAMP_SCHED_RAMP_EN
            int d, s;
            d  = (m_tgt[c] > m_cur[c]) ? m_tgt[c] - m_cur[c] : m_cur[c] - m_tgt[c];
            s  = (d < stp) ? d : stp;
            nv = (m_tgt[c] > m_cur[c]) ? m_cur[c] + s : m_cur[c] - s;
`else
            nv = m_tgt[c];
`endif
            if (nv != m_cur[c] || m_init) begin
                exp_q.push_back({8'(c * 2), 8'(nv % 256)});
                exp_q.push_back({8'(c * 2 + 1), 8'(nv / 256)});
                exp_busy += 4;
            end else begin
                exp_busy += 2;
            end
            m_cur[c] = nv;
        end
        m_init = 1'b0;
    endfunction

    // monitor
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   stall_cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_addr = 8'd0, prev_data = 8'd0;

    always @(negedge Clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && Wr_En) begin
                check_val("stall_addr", Wr_Addr, prev_addr);
                check_val("stall_data", Wr_Data, prev_data);
            end
            if (Wr_En && Wr_Ready) obs_q.push_back({Wr_Addr, Wr_Data});
            if (Wr_En && !Wr_Ready) stall_cyc <= stall_cyc + 1;
            if (Busy) busy_cnt <= busy_cnt + 1;
            if (Done) done_cnt <= done_cnt + 1;
            prev_stall <= Wr_En && !Wr_Ready;
            prev_addr  <= Wr_Addr;
            prev_data  <= Wr_Data;
        end
    end

    // ready driver: 0 = always ready, 1 = random, 2 = five-cycle stall per write burst
    int rdy_mode = 0;
    int stall_n  = 0;

    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0: Wr_Ready = 1'b1;
            1: Wr_Ready = 1'($urandom_range(0, 1));
            default: begin
                if (Wr_En && stall_n < 5) begin
                    Wr_Ready = 1'b0;
                    stall_n++;
                end else begin
                    Wr_Ready = 1'b1;
                    if (!Wr_En) stall_n = 0;
                end
            end
        endcase
    end

    task automatic set_tgt(int ch, int val);
        Tgt_WEn = 1'b1;
        Tgt_Ch  = 3'(ch);
        Tgt_Val = 15'(val);
        @(posedge Clk); #1;
        Tgt_WEn = 1'b0;
        if (ch < NCH) m_tgt[ch] = clamp_pw(val);
    endtask

    task automatic pulse_tick();
        Frame_Tick = 1'b1;
        @(posedge Clk); #1;
        Frame_Tick = 1'b0;
    endtask

    task automatic wait_done(int n);
        int k = 0;
        while (done_cnt < n && k < 5000) begin
            @(negedge Clk);
            k++;
        end
        repeat (3) @(posedge Clk);
        #1;
        check_val("done_cnt", done_cnt, n);
    endtask

    task automatic compare_writes();
        int n;
        check_val("n_writes", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_val($sformatf("wr%0d", i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_frame();
        int base;
        base     = done_cnt;
        exp_busy = 0;
        busy_cnt = 0;
        model_sweep(int'(Step));
        pulse_tick();
        wait_done(base + 1);
        if (rdy_mode == 0) check_val("busy_cyc", busy_cnt, exp_busy);
        compare_writes();
    endtask

    initial begin
        int found;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_wr_en", Wr_En, 0);
        check_val("rst_busy", Busy, 0);
        check_val("rst_done", Done, 0);
        check_val("rst_addr", Wr_Addr, 0);
        check_val("rst_data", Wr_Data, 0);
        rst = 1'b0;
        @(posedge Clk); #1;

        // first sweep writes every channel at the reset width
        rdy_mode = 0;
        Step = 8'd0;
        do_frame();
        do_frame();

        Step = 8'd40;
        set_tgt(2, 1600);
        repeat (4) do_frame();

        Step = 8'd255;
        set_tgt(5, 3000);
        repeat (3) do_frame();
        set_tgt(5, 10);
        repeat (3) do_frame();

        // held-off write handshake
        rdy_mode  = 2;
        stall_cyc = 0;
        Step = 8'd200;
        set_tgt(1, 1900);
        do_frame();
        check_val("stall_seen", (stall_cyc >= 5), 1);
        rdy_mode = 0;

        // three ticks inside one sweep: one extra sweep only
        Step = 8'd30;
        set_tgt(6, 1100);
        begin
            int base;
            base = done_cnt;
            model_sweep(int'(Step));
            model_sweep(int'(Step));
            pulse_tick();
            repeat (3) @(posedge Clk);
            #1;
            pulse_tick();
            repeat (3) @(posedge Clk);
            #1;
            pulse_tick();
            wait_done(base + 2);
            repeat (50) @(posedge Clk);
            #1;
            check_val("extra_sweeps", done_cnt, base + 2);
            check_val("idle_after", Busy, 0);
            compare_writes();
        end

        for (int it = 0; it < 25; it++) begin
            int nw;
            rdy_mode = int'($urandom_range(0, 1));
            Step = 8'($urandom_range(0, 255));
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 1) == 1)
                    set_tgt(int'($urandom_range(0, NCH - 1)), int'($urandom_range(900, 2100)));
                else
                    set_tgt(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 32767)));
            end
            do_frame();
        end

        // reset landing in WR_HI
        rdy_mode = 0;
        Step = 8'd100;
        set_tgt(3, (m_cur[3] > RESET_PW) ? 1000 : 2000);
        pulse_tick();
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge Clk);
            if (Wr_En && Wr_Addr[0]) found = 1;
        end
        check_val("reach_wr_hi", found, 1);
        rst = 1'b1;
        #1;
        check_val("abort_wr_en", Wr_En, 0);
        check_val("abort_busy", Busy, 0);
        repeat (2) @(posedge Clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        model_reset();
        Step = 8'($urandom_range(0, 255));
        do_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
